// File: rtl/mer_pkg.sv
// Shared types and widths for the MER measurement controller.
package mer_pkg;

  localparam int PHASE_W = 4;
  localparam int SQERR_W = 39;
  localparam int SAMP_W  = 18;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_CLEAR  = 2'd1,
    ST_ACCUM  = 2'd2,
    ST_SETTLE = 2'd3
  } mer_state_e;

  // One captured set of accumulator / mapper-power readings.
  typedef struct packed {
    logic signed [SQERR_W-1:0] sq_i;
    logic signed [SQERR_W-1:0] sq_q;
    logic signed [SAMP_W-1:0]  mp_i;
    logic signed [SAMP_W-1:0]  mp_q;
  } mer_data_t;

endpackage

// File: rtl/sym_phase_gen.sv
// Free-running 16-phase counter producing the sample and symbol enables.
// The counter is cleared by reset and held at 0 while run_i is low.
module sym_phase_gen
  import mer_pkg::*;
(
  input  logic clk,
  input  logic reset,
  input  logic run_i,
  output logic clk_smp_o,
  output logic clk_sym_o
);

  logic [PHASE_W-1:0] phase_q, phase_d;

  // Next phase: count while running, otherwise park at 0.
  always_comb begin
    phase_d = '0;
    if (run_i) phase_d = phase_q + PHASE_W'(1);
  end

  // Phase register.
  always_ff @(posedge clk) begin
    if (reset) phase_q <= '0;
    else       phase_q <= phase_d;
  end

  assign clk_smp_o = run_i && (phase_q[1:0] == 2'b11);
  assign clk_sym_o = run_i && (phase_q == {PHASE_W{1'b1}});

endmodule

// File: rtl/mer_meas_ctrl.sv
// MER measurement sequencer: clears the downstream accumulators, counts one
// window of 2^WIN_LOG2 symbols (and their slicer errors), lets the pipeline
// settle, then captures the accumulator outputs into a valid/ready result.
//
//   state  | meaning
//   IDLE   | stopped, phase parked at 0, no enables
//   CLEAR  | clear_accum high for one full 16-phase symbol period
//   ACCUM  | counting symbols and symbol errors of the window
//   SETTLE | SETTLE_CYC clocks; the last one captures the results
module mer_meas_ctrl
  import mer_pkg::*;
#(
  parameter int WIN_LOG2   = 20,
  parameter int SETTLE_CYC = 2
)
(
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      enable,
  input  logic                      sym_error_i,
  input  logic                      sym_error_q,
  input  logic signed [SQERR_W-1:0] sq_err_i,
  input  logic signed [SQERR_W-1:0] sq_err_q,
  input  logic signed [SAMP_W-1:0]  map_power_i,
  input  logic signed [SAMP_W-1:0]  map_power_q,
  output logic                      clk_smp,
  output logic                      clk_sym,
  output logic                      clear_accum,
  output logic                      res_valid,
  input  logic                      res_ready,
  output logic signed [SQERR_W-1:0] res_sq_err_i,
  output logic signed [SQERR_W-1:0] res_sq_err_q,
  output logic signed [SAMP_W-1:0]  res_map_power_i,
  output logic signed [SAMP_W-1:0]  res_map_power_q,
  output logic [WIN_LOG2:0]         res_sym_err_cnt,
  output logic                      overrun
);

  localparam int CNT_W = WIN_LOG2 + 1;
  localparam logic [CNT_W-1:0] WIN_SYMS   = CNT_W'(1) << WIN_LOG2;
  localparam logic [3:0]       SETTLE_LD  = 4'(SETTLE_CYC - 1);

  mer_state_e       state_q, state_d;
  logic [CNT_W-1:0] sym_cnt_q, sym_cnt_d;
  logic [CNT_W-1:0] err_cnt_q, err_cnt_d;
  logic [3:0]       settle_q, settle_d;
  mer_data_t        res_q, res_d;
  logic [CNT_W-1:0] res_cnt_q, res_cnt_d;
  logic             valid_q, valid_d;
  logic             ovr_q, ovr_d;
  logic             capture;
  logic             phase_restart;
  logic             win_done;

  // Phase must start at 0 in every CLEAR and read 0 throughout IDLE, so it
  // is restarted on any transition into those two states.
  assign phase_restart = (state_d != state_q) &&
                         ((state_d == ST_IDLE) || (state_d == ST_CLEAR));

  sym_phase_gen u_phase (
    .clk       (clk),
    .reset     (reset | phase_restart),
    .run_i     (state_q != ST_IDLE),
    .clk_smp_o (clk_smp),
    .clk_sym_o (clk_sym)
  );

  assign win_done = clk_sym && (sym_cnt_q + CNT_W'(1) == WIN_SYMS);
  assign capture  = (state_q == ST_SETTLE) && (settle_q == 4'd0);

  // Next-state logic; dropping enable aborts CLEAR/ACCUM but not SETTLE.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:   if (enable) state_d = ST_CLEAR;
      ST_CLEAR:  if (!enable) state_d = ST_IDLE;
                 else if (clk_sym) state_d = ST_ACCUM;
      ST_ACCUM:  if (!enable) state_d = ST_IDLE;
                 else if (win_done) state_d = ST_SETTLE;
      ST_SETTLE: if (capture) state_d = enable ? ST_CLEAR : ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  // Symbol/error counters and the settle down-counter.
  always_comb begin
    sym_cnt_d = sym_cnt_q;
    err_cnt_d = err_cnt_q;
    settle_d  = settle_q;
    if (state_q == ST_CLEAR) begin
      sym_cnt_d = '0;
      err_cnt_d = '0;
    end else if ((state_q == ST_ACCUM) && clk_sym) begin
      sym_cnt_d = sym_cnt_q + CNT_W'(1);
      err_cnt_d = err_cnt_q + {{WIN_LOG2{1'b0}}, (sym_error_i | sym_error_q)};
    end
    if ((state_d == ST_SETTLE) && (state_q != ST_SETTLE)) settle_d = SETTLE_LD;
    else if ((state_q == ST_SETTLE) && (settle_q != 4'd0)) settle_d = settle_q - 4'd1;
  end

  // Result capture and valid/ready/overrun handshake.
  always_comb begin
    res_d     = res_q;
    res_cnt_d = res_cnt_q;
    valid_d   = valid_q;
    ovr_d     = ovr_q;
    if (capture) begin
      res_d.sq_i = sq_err_i;
      res_d.sq_q = sq_err_q;
      res_d.mp_i = map_power_i;
      res_d.mp_q = map_power_q;
      res_cnt_d  = err_cnt_q;
      valid_d    = 1'b1;
      if (valid_q && !res_ready) ovr_d = 1'b1;
    end else if (valid_q && res_ready) begin
      valid_d = 1'b0;
    end
  end

  // All state registers; reset overrides any capture in the same clock.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      sym_cnt_q <= '0;
      err_cnt_q <= '0;
      settle_q  <= '0;
      res_q     <= '0;
      res_cnt_q <= '0;
      valid_q   <= 1'b0;
      ovr_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      sym_cnt_q <= sym_cnt_d;
      err_cnt_q <= err_cnt_d;
      settle_q  <= settle_d;
      res_q     <= res_d;
      res_cnt_q <= res_cnt_d;
      valid_q   <= valid_d;
      ovr_q     <= ovr_d;
    end
  end

  assign clear_accum     = (state_q == ST_CLEAR);
  assign res_valid       = valid_q;
  assign overrun         = ovr_q;
  assign res_sq_err_i    = res_q.sq_i;
  assign res_sq_err_q    = res_q.sq_q;
  assign res_map_power_i = res_q.mp_i;
  assign res_map_power_q = res_q.mp_q;
  assign res_sym_err_cnt = res_cnt_q;

endmodule

// File: tb/tb_mer_meas_ctrl.sv
// Bench for mer_meas_ctrl: directed scenarios followed by random traffic,
// every cycle compared against a window-timeline reference model.
module tb_mer_meas_ctrl;
  import mer_pkg::*;

  localparam int W       = 2;
  localparam int S       = 2;
  localparam int NSYM    = 1 << W;
  localparam int ACC_END = 16 + 16 * NSYM;  // offset of first SETTLE clock in a window

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset, enable, sym_error_i, sym_error_q, res_ready;
  logic signed [SQERR_W-1:0] sq_err_i, sq_err_q;
  logic signed [SAMP_W-1:0]  map_power_i, map_power_q;
  logic clk_smp, clk_sym, clear_accum, res_valid, overrun;
  logic signed [SQERR_W-1:0] res_sq_err_i, res_sq_err_q;
  logic signed [SAMP_W-1:0]  res_map_power_i, res_map_power_q;
  logic [W:0] res_sym_err_cnt;

  mer_meas_ctrl #(.WIN_LOG2(W), .SETTLE_CYC(S)) dut (
    .clk(clk), .reset(reset), .enable(enable),
    .sym_error_i(sym_error_i), .sym_error_q(sym_error_q),
    .sq_err_i(sq_err_i), .sq_err_q(sq_err_q),
    .map_power_i(map_power_i), .map_power_q(map_power_q),
    .clk_smp(clk_smp), .clk_sym(clk_sym), .clear_accum(clear_accum),
    .res_valid(res_valid), .res_ready(res_ready),
    .res_sq_err_i(res_sq_err_i), .res_sq_err_q(res_sq_err_q),
    .res_map_power_i(res_map_power_i), .res_map_power_q(res_map_power_q),
    .res_sym_err_cnt(res_sym_err_cnt), .overrun(overrun)
  );

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: position within the current measurement window.
  bit m_run = 0;
  int m_t = 0;
  int m_err = 0;
  int m_caps = 0;
  bit m_valid = 0, m_ovr = 0;
  logic signed [SQERR_W-1:0] m_sqi = '0, m_sqq = '0;
  logic signed [SAMP_W-1:0]  m_mpi = '0, m_mpq = '0;
  logic [W:0] m_cnt = '0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic bit m_capture_now();
    return m_run && (m_t == ACC_END + S - 1);
  endfunction

  // Check current outputs, advance the model with the current inputs, move
  // to just after the next falling edge.
  task automatic cycle();
    logic e_smp, e_sym, e_clr;
    int s;
    bit cap;
    e_smp = 1'b0; e_sym = 1'b0; e_clr = 1'b0;
    if (m_run) begin
      e_clr = (m_t < 16);
      if (m_t < ACC_END) begin
        e_sym = (m_t % 16 == 15);
        e_smp = (m_t % 4 == 3);
      end else begin
        s = m_t - ACC_END;
        e_smp = (s % 4 == 3);
      end
    end
    chk("clk_smp", clk_smp, e_smp);
    chk("clk_sym", clk_sym, e_sym);
    chk("clear_accum", clear_accum, e_clr);
    chk("res_valid", res_valid, m_valid);
    chk("overrun", overrun, m_ovr);
    chk("res_sq_err_i", res_sq_err_i, m_sqi);
    chk("res_sq_err_q", res_sq_err_q, m_sqq);
    chk("res_map_power_i", res_map_power_i, m_mpi);
    chk("res_map_power_q", res_map_power_q, m_mpq);
    chk("res_sym_err_cnt", res_sym_err_cnt, m_cnt);

    if (reset) begin
      m_run = 0; m_t = 0; m_err = 0; m_valid = 0; m_ovr = 0;
      m_sqi = '0; m_sqq = '0; m_mpi = '0; m_mpq = '0; m_cnt = '0;
    end else begin
      cap = m_capture_now();
      if (m_run && m_t >= 16 && m_t < ACC_END && (m_t % 16 == 15) &&
          (sym_error_i || sym_error_q)) m_err++;
      if (cap) begin
        m_sqi = sq_err_i; m_sqq = sq_err_q; m_mpi = map_power_i; m_mpq = map_power_q;
        m_cnt = m_err[W:0];
        m_caps++;
        if (m_valid && !res_ready) m_ovr = 1;
        m_valid = 1;
      end else if (m_valid && res_ready) begin
        m_valid = 0;
      end
      if (!m_run) begin
        if (enable) begin m_run = 1; m_t = 0; m_err = 0; end
      end else if (m_t < ACC_END) begin
        if (!enable) m_run = 0;
        else m_t++;
      end else if (cap) begin
        if (enable) begin m_t = 0; m_err = 0; end
        else m_run = 0;
      end else begin
        m_t++;
      end
    end
    @(negedge clk);
    #1;
  endtask

  initial begin
    int n_clr, n_sym, sym4_at, got, start, n_pulse, orall;
    bit dropped;
    reset = 1; enable = 0; sym_error_i = 0; sym_error_q = 0; res_ready = 0;
    sq_err_i = '0; sq_err_q = '0; map_power_i = '0; map_power_q = '0;
    @(negedge clk);
    #1;

    // Reset held with enable low: everything quiet.
    n_pulse = 0; orall = 0;
    for (int c = 0; c < 20; c++) begin
      if (clk_sym) n_pulse++;
      if (clk_smp | clk_sym | clear_accum | res_valid | overrun | (|res_sq_err_i) |
          (|res_sq_err_q) | (|res_map_power_i) | (|res_map_power_q) | (|res_sym_err_cnt))
        orall++;
      cycle();
    end
    chk("rst_sym_pulses", n_pulse, 0);
    chk("rst_any_output", orall, 0);

    // First window: timing, data path and error count.
    reset = 0; enable = 1; sq_err_i = 100; map_power_q = -5;
    n_clr = 0; n_sym = 0; sym4_at = -1; got = -1;
    for (int c = 0; c < 200 && got < 0; c++) begin
      sym_error_i = m_run && (m_t == 31 || m_t == 47);
      sym_error_q = m_run && (m_t == 47 || m_t == 63);
      if (res_valid) got = c;
      else begin
        if (clear_accum) n_clr++;
        if (clk_sym && !clear_accum) begin
          n_sym++;
          if (n_sym == 4) sym4_at = c;
        end
      end
      cycle();
    end
    sym_error_i = 0; sym_error_q = 0;
    chk("clear_len", n_clr, 16);
    chk("accum_syms", n_sym, 4);
    chk("valid_latency", got - sym4_at, 3);
    chk("w1_sq_err_i", res_sq_err_i, 64'(100));
    chk("w1_map_power_q", res_map_power_q, 64'(-5));
    chk("w1_err_cnt", res_sym_err_cnt, 3);

    // Second window unread: overwrite with overrun.
    sq_err_q = 777; start = m_caps;
    for (int c = 0; c < 300 && m_caps < start + 1; c++) cycle();
    chk("ovr_flag", overrun, 1);
    chk("ovr_valid", res_valid, 1);
    chk("ovr_data", res_sq_err_q, 64'(777));

    // Accept coinciding with the next capture: no overrun.
    reset = 1; enable = 0;
    cycle(); cycle();
    reset = 0; enable = 1; sq_err_q = 11; start = m_caps;
    for (int c = 0; c < 300 && m_caps < start + 1; c++) cycle();
    sq_err_q = 4242;
    for (int c = 0; c < 300 && m_caps < start + 2; c++) begin
      res_ready = m_capture_now();
      cycle();
    end
    res_ready = 0;
    chk("acc_cap_valid", res_valid, 1);
    chk("acc_cap_ovr", overrun, 0);
    chk("acc_cap_data", res_sq_err_q, 64'(4242));

    // Abort at the 2nd symbol of ACCUM: result retained, enables stop.
    dropped = 0;
    for (int c = 0; c < 200 && !dropped; c++) begin
      if (m_run && m_t == 47) begin dropped = 1; enable = 0; end
      cycle();
    end
    n_pulse = 0;
    for (int c = 0; c < 30; c++) begin
      if (clk_sym | clk_smp | clear_accum) n_pulse++;
      cycle();
    end
    chk("abort_quiet", n_pulse, 0);
    chk("abort_keep_data", res_sq_err_q, 64'(4242));
    chk("abort_keep_valid", res_valid, 1);

    // Random traffic.
    for (int c = 0; c < 8000; c++) begin
      reset       = ($urandom_range(0, 1499) == 0);
      enable      = ($urandom_range(0, 299) != 0);
      sym_error_i = ($urandom_range(0, 3) == 0);
      sym_error_q = ($urandom_range(0, 3) == 0);
      res_ready   = ($urandom_range(0, 3) == 0);
      sq_err_i    = SQERR_W'({$urandom(), $urandom()});
      sq_err_q    = SQERR_W'({$urandom(), $urandom()});
      map_power_i = SAMP_W'($urandom());
      map_power_q = SAMP_W'($urandom());
      cycle();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
